// File: rtl/ipu_ctrl.sv
// ipu_ctrl: debounces the nine grid buttons and raises an acknowledged interrupt per accepted press
module ipu_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W = 19
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [8:0] btn,
  input  logic       enable,
  input  logic       int_ack,
  output logic       ipu_int,
  output logic [3:0] grid_coord,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, DEBOUNCE, INT, WAIT_REL} state_t;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [8:0]       btn_m_q, btn_s_q, cand_q, cand_d;
  logic             int_q, int_d;
  logic [3:0]       coord_q, coord_d;
  logic             valid;
  function automatic logic [3:0] idx_of(input logic [8:0] v);
    idx_of = 4'hF;
    for (int i = 8; i >= 0; i--) if (v[i]) idx_of = 4'(i);
  endfunction
  assign valid      = (btn_s_q != '0) && ((btn_s_q & (btn_s_q - 9'd1)) == '0);
  assign cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign ipu_int    = int_q;
  assign grid_coord = coord_q;
  assign busy       = (state_q != IDLE);
  // synchronizer, state, counter and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_m_q <= '0;
      btn_s_q <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
      int_q   <= 1'b0;
      coord_q <= 4'hF;
    end else begin
      btn_m_q <= btn;
      btn_s_q <= btn_m_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      int_q   <= int_d;
      coord_q <= coord_d;
    end
  end
  // press acceptance, interrupt hold and release qualification
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    int_d   = int_q;
    coord_d = coord_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (enable && valid) begin
          cand_d  = btn_s_q;
          state_d = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (!enable || btn_s_q != cand_q) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == CNT_MAX) begin
          coord_d = idx_of(cand_q);
          int_d   = 1'b1;
          cnt_d   = '0;
          state_d = INT;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      INT: begin
        if (int_ack) begin
          int_d   = 1'b0;
          cnt_d   = '0;
          state_d = WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (btn_s_q != '0) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_ipu_ctrl.sv
// tb_ipu_ctrl: scoreboard bench for ipu_ctrl with a short debounce window
module tb_ipu_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [8:0] btn = '0;
  logic       enable = 1'b0;
  logic       int_ack = 1'b0;
  logic       ipu_int;
  logic [3:0] grid_coord;
  logic       busy;
  int total = 0;
  int bad = 0;
  logic [3:0] exp_q[$];

  ipu_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .btn(btn), .enable(enable), .int_ack(int_ack),
    .ipu_int(ipu_int), .grid_coord(grid_coord), .busy(busy)
  );

  always #5 clk = ~clk;

  // every rising interrupt consumes one expected coordinate
  initial begin
    logic prev_int;
    logic [3:0] exp_c;
    prev_int = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && ipu_int && !prev_int) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_int got coord=%0d expected no interrupt", grid_coord);
        end else begin
          exp_c = exp_q.pop_front();
          if (grid_coord !== exp_c) begin
            bad++;
            $display("FAIL int_coord got=%0d expected=%0d", grid_coord, exp_c);
          end
        end
      end
      prev_int = ipu_int;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    btn = '0;
    enable = 1'b0;
    int_ack = 1'b0;
    exp_q.delete();
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic wait_int(string nm);
    int k = 0;
    while (!ipu_int && k < 20) begin
      tick();
      k++;
    end
    total++;
    if (ipu_int !== 1'b1) begin
      bad++;
      $display("FAIL %s_timeout ipu_int=%b expected 1", nm, ipu_int);
    end
    tick();
  endtask

  task automatic do_ack(string nm);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    total++;
    if (ipu_int !== 1'b0) begin
      bad++;
      $display("FAIL %s_ack ipu_int=%b expected 0", nm, ipu_int);
    end
  endtask

  task automatic release_btn(string nm);
    btn = '0;
    tick(8);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_release busy=%b expected 0", nm, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    btn = 9'h010;
    enable = 1'b1;
    tick(3);
    total++;
    if ({ipu_int, grid_coord, busy} !== {1'b0, 4'hF, 1'b0}) begin
      bad++;
      $display("FAIL reset_hold got int=%b coord=%h busy=%b expected 0 f 0", ipu_int, grid_coord, busy);
    end
    btn = '0;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      total++;
      if ({ipu_int, grid_coord, busy} !== {1'b0, 4'hF, 1'b0}) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d got int=%b coord=%h busy=%b expected 0 f 0", i, ipu_int, grid_coord, busy);
      end
    end
  endtask

  task automatic test_bounce();
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      btn = (i < 20) ? ((i / 2) % 2 == 0 ? 9'h004 : 9'h000) : 9'h003;
      tick();
      total++;
      if (ipu_int !== 1'b0 || grid_coord !== 4'hF) begin
        bad++;
        $display("FAIL bounce cyc=%0d got int=%b coord=%h expected 0 f", i, ipu_int, grid_coord);
      end
    end
    btn = '0;
    tick(8);
  endtask

  task automatic test_clean_press();
    do_reset();
    enable = 1'b1;
    btn = 9'h010;
    exp_q.push_back(4'd4);
    tick(6);
    total++;
    if (ipu_int !== 1'b0) begin
      bad++;
      $display("FAIL press_early ipu_int=%b expected 0 at cycle 6", ipu_int);
    end
    tick();
    total++;
    if (ipu_int !== 1'b1 || grid_coord !== 4'd4) begin
      bad++;
      $display("FAIL press_latency got int=%b coord=%0d expected 1 4 at cycle 7", ipu_int, grid_coord);
    end
    do_ack("press");
    total++;
    if (grid_coord !== 4'd4) begin
      bad++;
      $display("FAIL press_coord_hold got=%0d expected=4", grid_coord);
    end
    release_btn("press");
  endtask

  task automatic test_no_repeat();
    int highs = 0;
    do_reset();
    enable = 1'b1;
    btn = 9'h100;
    exp_q.push_back(4'd8);
    wait_int("hold");
    do_ack("hold");
    for (int i = 0; i < 50; i++) begin
      tick();
      if (ipu_int) highs++;
    end
    total++;
    if (highs !== 0 || grid_coord !== 4'd8) begin
      bad++;
      $display("FAIL hold_repeat got highs=%0d coord=%0d expected 0 8", highs, grid_coord);
    end
    release_btn("hold");
    btn = 9'h001;
    exp_q.push_back(4'd0);
    wait_int("second");
    total++;
    if (grid_coord !== 4'd0) begin
      bad++;
      $display("FAIL second_coord got=%0d expected=0", grid_coord);
    end
    do_ack("second");
    release_btn("second");
  endtask

  task automatic test_enable_ack();
    int highs = 0;
    do_reset();
    btn = 9'h020;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ipu_int || busy) highs++;
    end
    total++;
    if (highs !== 0) begin
      bad++;
      $display("FAIL disabled_press got active_cycles=%0d expected 0", highs);
    end
    enable = 1'b1;
    exp_q.push_back(4'd5);
    wait_int("enable");
    enable = 1'b0;
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!ipu_int) highs++;
    end
    total++;
    if (highs !== 0) begin
      bad++;
      $display("FAIL int_dropped got low_cycles=%0d expected 0", highs);
    end
    do_ack("enable");
    release_btn("enable");
    enable = 1'b1;
    btn = 9'h040;
    exp_q.push_back(4'd6);
    tick(3);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    tick(2);
    total++;
    if (ipu_int !== 1'b0) begin
      bad++;
      $display("FAIL debounce_ack_early ipu_int=%b expected 0", ipu_int);
    end
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    total++;
    if (ipu_int !== 1'b1 || grid_coord !== 4'd6) begin
      bad++;
      $display("FAIL debounce_ack_fire got int=%b coord=%0d expected 1 6", ipu_int, grid_coord);
    end
    tick();
    total++;
    if (ipu_int !== 1'b1) begin
      bad++;
      $display("FAIL same_cycle_ack ipu_int=%b expected 1", ipu_int);
    end
    do_ack("boundary");
    release_btn("boundary");
  endtask

  task automatic test_reset_mid();
    do_reset();
    enable = 1'b1;
    btn = 9'h080;
    exp_q.push_back(4'd7);
    wait_int("midrst");
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({ipu_int, grid_coord, busy} !== {1'b0, 4'hF, 1'b0}) begin
      bad++;
      $display("FAIL reset_mid got int=%b coord=%h busy=%b expected 0 f 0", ipu_int, grid_coord, busy);
    end
    btn = '0;
    tick(2);
    rst_n = 1'b1;
    tick(4);
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_clean_press();
    test_no_repeat();
    test_enable_ack();
    test_reset_mid();
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL scoreboard_leftover got=%0d expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ipu_ctrl.md
# ipu_ctrl

Input processing unit for the tic-tac-toe board. It synchronizes and debounces the nine grid push-buttons and encodes a single accepted press as a 4-bit grid coordinate. It then raises the processor interrupt and holds it until the fetch stage acknowledges. It drives the `ipu_int` / `grid_coord` inputs of the processor and consumes its `int_ack` output.

## Interface

Parameters:

- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept a press or a release (10 ms at 50 MHz). Minimum 2.
- `CNT_W`, default 19: counter width. Must hold `DEBOUNCE_CYCLES`.

Ports:

- `clk`  in  1  system clock. Single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn`  in  9  raw grid buttons, active-high, asynchronous. `btn[i]` is cell i (row-major, 0 = top-left).
- `enable`  in  1  accept new presses when high (game in progress).
- `int_ack`  in  1  interrupt acknowledge from fetch, single-cycle pulse.
- `ipu_int`  out  1  interrupt request, level, registered.
- `grid_coord`  out  4  last accepted cell, 0..8. 4'hF = none since reset. Registered.
- `busy`  out  1  high in any state other than IDLE.

## Operation

- `btn` passes through a 2-flop synchronizer (`btn_s`). All logic below uses `btn_s`.
- `valid` is true when `btn_s` is exactly one-hot. `idx` is the bit position of the set bit.
- FSM states: IDLE, DEBOUNCE, INT, WAIT_REL.
- **IDLE**
  - Counter is 0.
  - If `enable` and `valid`: capture `btn_s` into `cand`, go to DEBOUNCE.
  - Zero or multiple buttons pressed: stay in IDLE.
- **DEBOUNCE**
  - Counter increments each cycle while `btn_s == cand` and `enable` is high.
  - Any change of `btn_s` or `enable` low: go to IDLE, counter cleared.
  - When the counter reaches `DEBOUNCE_CYCLES`-1 with the condition still holding:
    - `grid_coord` <= `idx(cand)`.
    - `ipu_int` <= 1.
    - Go to INT.
- **INT**
  - `ipu_int` is held at 1 and `grid_coord` is held.
  - `enable` is ignored, so a pending interrupt is never dropped.
  - Button activity is ignored.
  - On `int_ack`=1: `ipu_int` <= 0, counter cleared, go to WAIT_REL.
- **WAIT_REL**
  - Counter increments while `btn_s == 0` and is cleared on any nonzero `btn_s`.
  - When the counter reaches `DEBOUNCE_CYCLES`-1: go to IDLE.
  - This guarantees one interrupt per physical press, with no auto-repeat.
- `grid_coord` changes only on the DEBOUNCE→INT transition. It stays stable from there until the next accepted press, so a `read_coord` instruction executed any time after the ack sees the same value.
- Counter saturates. It never wraps.

## Timing

- Reset values (asynchronous, immediate on `rst_n`=0):
  - `ipu_int`=0, `grid_coord`=4'hF, `busy`=0.
  - State IDLE, counter 0, synchronizer flops 0, `cand`=0.
- Reset asserted mid-operation (including INT) drops `ipu_int` asynchronously. No pending request survives reset.
- Press latency, from the first stable edge of `btn` to `ipu_int`=1:
  - 2 cycles synchronizer + 1 cycle IDLE→DEBOUNCE + `DEBOUNCE_CYCLES` cycles.
  - Total `DEBOUNCE_CYCLES`+3 cycles.
- `ipu_int` deasserts on the clock edge that samples `int_ack`=1. It is low in the following cycle.
- `int_ack` sampled while in IDLE, DEBOUNCE or WAIT_REL is ignored.
- An `int_ack` in the same cycle as the DEBOUNCE→INT transition is ignored. The acknowledge only counts when seen while in INT.
- Release latency, from all buttons low at the pins to return to IDLE after the ack: 2 + `DEBOUNCE_CYCLES` cycles.
- `busy` is combinational from the state register: `busy` = (state != IDLE).

## Test plan

Run with `DEBOUNCE_CYCLES`=4.

1. **Reset**
   - Stimulus: hold `rst_n`=0, drive `btn`=9'h010.
   - Required: `ipu_int`=0, `grid_coord`=4'hF, `busy`=0.
   - After release with `btn`=0: outputs unchanged for 20 cycles.
2. **Clean press with ack**
   - Stimulus: `enable`=1, `btn`=9'h010 held.
   - Required: `ipu_int` rises exactly 7 cycles later with `grid_coord`=4.
   - Then pulse `int_ack` once: `ipu_int`=0 on the next cycle, `grid_coord` stays 4.
3. **Bounce and multi-press rejection**
   - Stimulus: toggle `btn[2]` every 2 cycles for 20 cycles, then `btn`=9'h003 held for 20 cycles.
   - Required: `ipu_int` stays 0 and `grid_coord` stays 4'hF throughout.
4. **No repeat while held**
   - Stimulus: press `btn[8]`, ack, keep holding 50 cycles.
   - Required: exactly one `ipu_int` pulse, `grid_coord`=8.
   - Then release for ≥6 cycles and press `btn[0]`: second interrupt with `grid_coord`=0.
5. **Enable and ack boundaries**
   - Stimulus: `enable`=0 with `btn[5]` held.
   - Required: no interrupt.
   - Stimulus: drop `enable` while in INT.
   - Required: `ipu_int` stays 1 until `int_ack`.
   - Stimulus: `int_ack` pulsed during DEBOUNCE.
   - Required: ignored, and the interrupt still fires.
6. **Reset mid-request**
   - Stimulus: assert `rst_n`=0 while `ipu_int`=1.
   - Required: `ipu_int`=0 and `grid_coord`=4'hF immediately, before the next clock edge.
